// File: rtl/branch_target_predictor_pkg.sv
// Shared predictor constants: default geometry and direction-counter encodings.
// EX and IF1 import this to recompute table index/tag consistently.
package branch_target_predictor_pkg;

    localparam int unsigned DEF_WORD     = 32;
    localparam int unsigned DEF_ENTRIES  = 64;
    localparam int unsigned DEF_CNT_BITS = 2;
    localparam int unsigned DEF_TAG_BITS = 8;

    // Counter value loaded at reset: weakly not taken.
    function automatic int unsigned cnt_weak_not_taken(int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    // Counter value loaded on allocation: weakly taken.
    function automatic int unsigned cnt_weak_taken(int unsigned bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Combinational saturating up/down counter used on the predictor training path.
module sat_counter
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned CNT_BITS = DEF_CNT_BITS
) (
    input  logic [CNT_BITS-1:0] cnt,
    input  logic                taken,
    output logic [CNT_BITS-1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != '1) cnt_next = cnt + CNT_BITS'(1);
        end else begin
            if (cnt != '0) cnt_next = cnt - CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Tagged direction/target table: lookup with the IF0 PC answers in IF1,
// EX resolution trains the table every cycle regardless of stall.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned WORD     = DEF_WORD,
    parameter int unsigned ENTRIES  = DEF_ENTRIES,
    parameter int unsigned CNT_BITS = DEF_CNT_BITS,
    parameter int unsigned TAG_BITS = DEF_TAG_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [WORD-1:0] lk_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [WORD-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [WORD-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [WORD-1:0] upd_target
);

    localparam int unsigned IDX_BITS = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_INIT  = CNT_BITS'(cnt_weak_not_taken(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_ALLOC = CNT_BITS'(cnt_weak_taken(CNT_BITS));

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
    logic [WORD-1:0]     target_q [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_BITS-1:0] lk_tag, upd_tag;
    logic                lk_hit, lk_taken;
    logic [WORD-1:0]     lk_target;
    logic                upd_hit;
    logic [CNT_BITS-1:0] upd_cnt_next;
    logic                unused_upd_pc;

    assign lk_idx  = lk_pc[IDX_BITS+1:2];
    assign lk_tag  = lk_pc[IDX_BITS+2 +: TAG_BITS];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
    assign upd_tag = upd_pc[IDX_BITS+2 +: TAG_BITS];
    assign unused_upd_pc = ^upd_pc;

    // Reads see the pre-edge table, which gives read-before-write on index collisions.
    always_comb begin
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken  = lk_hit && cnt_q[lk_idx][CNT_BITS-1];
        lk_target = lk_taken ? target_q[lk_idx] : lk_pc + WORD'(4);
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_counter #(
        .CNT_BITS(CNT_BITS)
    ) u_sat_counter (
        .cnt      (cnt_q[upd_idx]),
        .taken    (upd_taken),
        .cnt_next (upd_cnt_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[IDX_BITS'(i)] <= 1'b0;
                cnt_q[IDX_BITS'(i)]   <= CNT_INIT;
            end
        end else begin
            if (!stall) begin
                pred_hit    <= lk_hit;
                pred_taken  <= lk_taken;
                pred_target <= lk_target;
            end
            if (upd_valid) begin
                if (upd_hit) begin
                    cnt_q[upd_idx] <= upd_cnt_next;
                    if (upd_taken) target_q[upd_idx] <= upd_target;
                end else if (upd_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    cnt_q[upd_idx]    <= CNT_ALLOC;
                    target_q[upd_idx] <= upd_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed vector table,
// stall/reset sequence, and randomized traffic against a table model.
module tb_branch_target_predictor;

    localparam int unsigned ENTRIES   = 64;
    localparam int unsigned TAG_MOD   = 256;
    localparam int          CNT_MAX   = 3;
    localparam int          CNT_INIT  = 1;
    localparam int          CNT_ALLOC = 2;

    logic        clk = 1'b0;
    logic        rst, stall, upd_valid, upd_taken;
    logic [31:0] lk_pc, upd_pc, upd_target;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;

    always #5 clk = ~clk;

    branch_target_predictor #(
        .WORD(32), .ENTRIES(64), .CNT_BITS(2), .TAG_BITS(8)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .lk_pc(lk_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one record per table slot plus the IF1 output register.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic        m_hit = 1'b0, m_taken = 1'b0;
    logic [31:0] m_target = '0;

    function automatic int unsigned idx_of(logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return (pc >> 8) % TAG_MOD;
    endfunction

    function automatic void model_step();
        int unsigned i;
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_cnt[k]   = CNT_INIT;
            end
            m_hit = 1'b0; m_taken = 1'b0; m_target = '0;
            return;
        end
        if (!stall) begin
            i = idx_of(lk_pc);
            m_hit    = m_valid[i] && (m_tag[i] == tag_of(lk_pc));
            m_taken  = m_hit && (m_cnt[i] >= CNT_ALLOC);
            m_target = m_taken ? m_tgt[i] : lk_pc + 32'd4;
        end
        if (upd_valid) begin
            i = idx_of(upd_pc);
            if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
                if (upd_taken) begin
                    m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
                    m_tgt[i] = upd_target;
                end else begin
                    m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(upd_pc);
                m_cnt[i]   = CNT_ALLOC;
                m_tgt[i]   = upd_target;
            end
        end
    endfunction

    task automatic cyc(input logic r, input logic s, input logic [31:0] lk,
                       input logic uv, input logic [31:0] up, input logic ut,
                       input logic [31:0] utg);
        @(negedge clk);
        rst = r; stall = s; lk_pc = lk;
        upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic eh, input logic et,
                         input logic [31:0] etg);
        checks++;
        if (pred_hit !== eh || pred_taken !== et || pred_target !== etg) begin
            errors++;
            $display("FAIL %s: got hit=%0b taken=%0b target=%h, expected hit=%0b taken=%0b target=%h",
                     name, pred_hit, pred_taken, pred_target, eh, et, etg);
        end
    endtask

    typedef struct {
        logic        r, s;
        logic [31:0] lk;
        logic        uv;
        logic [31:0] up;
        logic        ut;
        logic [31:0] utg;
        logic        eh, et;
        logic [31:0] etg;
    } vec_t;

    vec_t vt[$];

    function automatic void add(logic r, logic s, logic [31:0] lk, logic uv,
                                logic [31:0] up, logic ut, logic [31:0] utg,
                                logic eh, logic et, logic [31:0] etg);
        vec_t v;
        v.r = r; v.s = s; v.lk = lk; v.uv = uv; v.up = up; v.ut = ut; v.utg = utg;
        v.eh = eh; v.et = et; v.etg = etg;
        vt.push_back(v);
    endfunction

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 7) == 0)
            return 32'hFFFF_FFFC - (32'($urandom_range(0, 3)) << 2);
        return 32'h1C00_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        rst = 1'b0; stall = 1'b0; lk_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

        //   rst s  lk_pc          uv up             ut utg            hit tk target
        add(1, 0, 32'h1C00_0000, 1, 32'h1C00_0010, 1, 32'h1C00_0100, 0, 0, 32'h0000_0000);
        add(0, 0, 32'h1C00_0000, 0, 32'h0,         0, 32'h0,         0, 0, 32'h1C00_0004);
        add(0, 0, 32'h1C00_0010, 0, 32'h0,         0, 32'h0,         0, 0, 32'h1C00_0014);
        add(0, 0, 32'h1C00_0000, 1, 32'h1C00_0010, 1, 32'h1C00_0100, 0, 0, 32'h1C00_0004);
        add(0, 0, 32'h1C00_0010, 0, 32'h0,         0, 32'h0,         1, 1, 32'h1C00_0100);
        add(0, 0, 32'h1C00_0010, 1, 32'h1C00_0010, 0, 32'h0,         1, 1, 32'h1C00_0100);
        add(0, 0, 32'h1C00_0010, 1, 32'h1C00_0010, 0, 32'h0,         1, 0, 32'h1C00_0014);
        add(0, 0, 32'h1C00_0010, 1, 32'h1C00_0010, 0, 32'h0,         1, 0, 32'h1C00_0014);
        add(0, 0, 32'h1C00_0010, 1, 32'h1C00_0010, 1, 32'h1C00_0200, 1, 0, 32'h1C00_0014);
        add(0, 0, 32'h1C00_0010, 1, 32'h1C00_0010, 1, 32'h1C00_0200, 1, 0, 32'h1C00_0014);
        add(0, 0, 32'h1C00_0010, 0, 32'h0,         0, 32'h0,         1, 1, 32'h1C00_0200);
        add(0, 0, 32'h1C00_0010, 1, 32'h1C00_0110, 1, 32'h1C00_0300, 1, 1, 32'h1C00_0200);
        add(0, 0, 32'h1C00_0010, 0, 32'h0,         0, 32'h0,         0, 0, 32'h1C00_0014);
        add(0, 0, 32'h1C00_0110, 0, 32'h0,         0, 32'h0,         1, 1, 32'h1C00_0300);
        add(0, 0, 32'h1C00_0020, 1, 32'h1C00_0020, 1, 32'h1C00_0400, 0, 0, 32'h1C00_0024);
        add(0, 0, 32'h1C00_0020, 0, 32'h0,         0, 32'h0,         1, 1, 32'h1C00_0400);
        add(0, 0, 32'h1C00_0000, 1, 32'h1C00_0030, 0, 32'h1C00_0800, 0, 0, 32'h1C00_0004);
        add(0, 0, 32'h1C00_0030, 0, 32'h0,         0, 32'h0,         0, 0, 32'h1C00_0034);
        add(0, 0, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0000);

        foreach (vt[k]) begin
            cyc(vt[k].r, vt[k].s, vt[k].lk, vt[k].uv, vt[k].up, vt[k].ut, vt[k].utg);
            check($sformatf("vec%0d", k), vt[k].eh, vt[k].et, vt[k].etg);
        end

        // Stall freezes outputs while lk_pc moves; training continues underneath.
        cyc(0, 0, 32'h1C00_0020, 0, 32'h0, 0, 32'h0);
        check("pre_stall", 1, 1, 32'h1C00_0400);
        cyc(0, 1, 32'h1C00_0000, 0, 32'h0, 0, 32'h0);
        check("stall1", 1, 1, 32'h1C00_0400);
        cyc(0, 1, 32'h1C00_0110, 1, 32'h1C00_0040, 1, 32'h1C00_0500);
        check("stall2", 1, 1, 32'h1C00_0400);
        cyc(0, 1, 32'h1C00_0050, 0, 32'h0, 0, 32'h0);
        check("stall3", 1, 1, 32'h1C00_0400);
        cyc(0, 0, 32'h1C00_0040, 0, 32'h0, 0, 32'h0);
        check("trained_in_stall", 1, 1, 32'h1C00_0500);
        cyc(1, 1, 32'h1C00_0020, 1, 32'h1C00_0050, 1, 32'h1C00_0600);
        check("rst_in_stall", 0, 0, 32'h0000_0000);
        cyc(0, 0, 32'h1C00_0040, 0, 32'h0, 0, 32'h0);
        check("cleared_40", 0, 0, 32'h1C00_0044);
        cyc(0, 0, 32'h1C00_0020, 0, 32'h0, 0, 32'h0);
        check("cleared_20", 0, 0, 32'h1C00_0024);
        cyc(0, 0, 32'h1C00_0110, 0, 32'h0, 0, 32'h0);
        check("cleared_110", 0, 0, 32'h1C00_0114);
        cyc(0, 0, 32'h1C00_0050, 0, 32'h0, 0, 32'h0);
        check("dropped_upd", 0, 0, 32'h1C00_0054);

        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, rand_pc(),
                $urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 2) != 0,
                $urandom() & 32'hFFFF_FFFC);
            check($sformatf("rand%0d", n), m_hit, m_taken, m_target);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
